// File: rtl/xpu_vpu_pc_tn_vlsu_fp_pkg.sv
// Shared definitions for the VLSU floating-point NaN checker:
// SEW encodings, exponent/mantissa widths per format and canonical qNaNs.
package xpu_vpu_pc_tn_vlsu_fp_pkg;

    typedef enum logic [1:0] {
        SEW_BYP  = 2'b00,
        SEW_FP16 = 2'b01,
        SEW_FP32 = 2'b10,
        SEW_FP64 = 2'b11
    } sew_e;

    localparam int unsigned FP16_EXP = 5;
    localparam int unsigned FP16_MAN = 10;
    localparam int unsigned FP32_EXP = 8;
    localparam int unsigned FP32_MAN = 23;
    localparam int unsigned FP64_EXP = 11;
    localparam int unsigned FP64_MAN = 52;

    localparam logic [15:0] CANON_FP16 = 16'h7E00;
    localparam logic [31:0] CANON_FP32 = 32'h7FC0_0000;
    localparam logic [63:0] CANON_FP64 = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/xpu_vpu_pc_tn_vlsu_fp_elem_cls.sv
// Combinational NaN classifier for one IEEE-754 element.
// The sign bit is not needed, so only exponent and mantissa are taken.
module xpu_vpu_pc_tn_vlsu_fp_elem_cls #(
    parameter int unsigned EXPONENT_SIZE = 8,
    parameter int unsigned MANTISSA_SIZE = 23
) (
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE-1:0] exp_man,
    output logic                                   is_qnan,
    output logic                                   is_snan
);

    logic [EXPONENT_SIZE-1:0] exp_f;
    logic [MANTISSA_SIZE-1:0] man_f;
    logic                     is_nan;

    // NaN: exponent all ones with a nonzero mantissa; mantissa MSB picks quiet/signalling
    always_comb begin
        exp_f   = exp_man[MANTISSA_SIZE +: EXPONENT_SIZE];
        man_f   = exp_man[MANTISSA_SIZE-1:0];
        is_nan  = (&exp_f) & (|man_f);
        is_qnan = is_nan & man_f[MANTISSA_SIZE-1];
        is_snan = is_nan & ~man_f[MANTISSA_SIZE-1];
    end

endmodule

// File: rtl/xpu_vpu_pc_tn_vlsu_fp_nan_chk.sv
// SEW-configurable NaN classifier / canonicaliser for the VLSU data path.
// Two-stage valid/ready pipeline: S0 holds raw beat plus per-format class
// bits, S1 holds the SEW-selected, masked, canonicalised result and flags.
module xpu_vpu_pc_tn_vlsu_fp_nan_chk
    import xpu_vpu_pc_tn_vlsu_fp_pkg::*;
#(
    parameter int unsigned DW    = 128,
    parameter int unsigned NE    = DW / 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             cpuclk,
    input  logic             cpurst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [DW-1:0]    in_data,
    input  logic [1:0]       in_sew,
    input  logic [NE-1:0]    in_emask,
    input  logic             in_canon,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [DW-1:0]    out_data,
    output logic [NE-1:0]    out_qnan,
    output logic [NE-1:0]    out_snan,
    input  logic             clr_sticky,
    output logic             snan_sticky,
    output logic [CNT_W-1:0] nan_cnt
);

    localparam int unsigned N32 = NE / 2;
    localparam int unsigned N64 = NE / 4;

    logic [NE-1:0]  c16_q, c16_s;
    logic [N32-1:0] c32_q, c32_s;
    logic [N64-1:0] c64_q, c64_s;

    logic           s0_vld;
    logic [DW-1:0]  s0_data;
    sew_e           s0_sew;
    logic [NE-1:0]  s0_mask;
    logic           s0_canon;
    logic [NE-1:0]  s0_q16, s0_s16;
    logic [N32-1:0] s0_q32, s0_s32;
    logic [N64-1:0] s0_q64, s0_s64;

    logic           s1_vld;
    logic           s1_adv;
    logic           in_fire;
    logic           out_fire;

    logic [DW-1:0]  s1_data_d;
    logic [NE-1:0]  s1_q_d, s1_s_d;

    logic [CNT_W:0]   nan_pc;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;

    assign s1_adv   = ~s1_vld | out_rdy;
    assign in_rdy   = ~s0_vld | s1_adv;
    assign in_fire  = in_vld & in_rdy;
    assign out_vld  = s1_vld;
    assign out_fire = s1_vld & out_rdy;

    // Every lane of every format is classified in parallel; S1 picks by SEW.
    for (genvar g = 0; g < NE; g++) begin : g_fp16
        xpu_vpu_pc_tn_vlsu_fp_elem_cls #(
            .EXPONENT_SIZE(FP16_EXP),
            .MANTISSA_SIZE(FP16_MAN)
        ) u_cls (
            .exp_man(in_data[g*16 +: 15]),
            .is_qnan(c16_q[g]),
            .is_snan(c16_s[g])
        );
    end

    for (genvar g = 0; g < N32; g++) begin : g_fp32
        xpu_vpu_pc_tn_vlsu_fp_elem_cls #(
            .EXPONENT_SIZE(FP32_EXP),
            .MANTISSA_SIZE(FP32_MAN)
        ) u_cls (
            .exp_man(in_data[g*32 +: 31]),
            .is_qnan(c32_q[g]),
            .is_snan(c32_s[g])
        );
    end

    for (genvar g = 0; g < N64; g++) begin : g_fp64
        xpu_vpu_pc_tn_vlsu_fp_elem_cls #(
            .EXPONENT_SIZE(FP64_EXP),
            .MANTISSA_SIZE(FP64_MAN)
        ) u_cls (
            .exp_man(in_data[g*64 +: 63]),
            .is_qnan(c64_q[g]),
            .is_snan(c64_s[g])
        );
    end

    // S0 register: capture raw beat and class bits on input transfer
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            s0_vld   <= 1'b0;
            s0_data  <= '0;
            s0_sew   <= SEW_BYP;
            s0_mask  <= '0;
            s0_canon <= 1'b0;
            s0_q16   <= '0;
            s0_s16   <= '0;
            s0_q32   <= '0;
            s0_s32   <= '0;
            s0_q64   <= '0;
            s0_s64   <= '0;
        end else begin
            s0_vld <= in_fire | (s0_vld & ~s1_adv);
            if (in_fire) begin
                s0_data  <= in_data;
                s0_sew   <= sew_e'(in_sew);
                s0_mask  <= in_emask;
                s0_canon <= in_canon;
                s0_q16   <= c16_q;
                s0_s16   <= c16_s;
                s0_q32   <= c32_q;
                s0_s32   <= c32_s;
                s0_q64   <= c64_q;
                s0_s64   <= c64_s;
            end
        end
    end

    // Per-lane SEW mux: apply mask, emit flags, substitute canonical qNaN
    always_comb begin
        s1_data_d = s0_data;
        s1_q_d    = '0;
        s1_s_d    = '0;
        case (s0_sew)
            SEW_FP16: begin
                for (int unsigned i = 0; i < NE; i++) begin
                    if (s0_mask[i]) begin
                        s1_q_d[i] = s0_q16[i];
                        s1_s_d[i] = s0_s16[i];
                        if (s0_canon & (s0_q16[i] | s0_s16[i]))
                            s1_data_d[i*16 +: 16] = CANON_FP16;
                    end
                end
            end
            SEW_FP32: begin
                for (int unsigned i = 0; i < N32; i++) begin
                    if (s0_mask[i]) begin
                        s1_q_d[i] = s0_q32[i];
                        s1_s_d[i] = s0_s32[i];
                        if (s0_canon & (s0_q32[i] | s0_s32[i]))
                            s1_data_d[i*32 +: 32] = CANON_FP32;
                    end
                end
            end
            SEW_FP64: begin
                for (int unsigned i = 0; i < N64; i++) begin
                    if (s0_mask[i]) begin
                        s1_q_d[i] = s0_q64[i];
                        s1_s_d[i] = s0_s64[i];
                        if (s0_canon & (s0_q64[i] | s0_s64[i]))
                            s1_data_d[i*64 +: 64] = CANON_FP64;
                    end
                end
            end
            default: ; // bypass: data through untouched, no flags
        endcase
    end

    // S1 register: output stage, held while downstream stalls
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            s1_vld   <= 1'b0;
            out_data <= '0;
            out_qnan <= '0;
            out_snan <= '0;
        end else if (s1_adv) begin
            s1_vld <= s0_vld;
            if (s0_vld) begin
                out_data <= s1_data_d;
                out_qnan <= s1_q_d;
                out_snan <= s1_s_d;
            end
        end
    end

    // NaN popcount of the delivered beat, added to the (possibly cleared) count with saturation
    always_comb begin
        nan_pc = '0;
        for (int unsigned i = 0; i < NE; i++)
            nan_pc = nan_pc + (CNT_W+1)'(out_qnan[i] | out_snan[i]);
        cnt_sum = {1'b0, (clr_sticky ? {CNT_W{1'b0}} : nan_cnt)} + nan_pc;
        cnt_nxt = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // Sticky sNaN flag and NaN counter; clear applies before same-cycle transfer
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            snan_sticky <= 1'b0;
            nan_cnt     <= '0;
        end else if (out_fire) begin
            snan_sticky <= (|out_snan) | (snan_sticky & ~clr_sticky);
            nan_cnt     <= cnt_nxt;
        end else if (clr_sticky) begin
            snan_sticky <= 1'b0;
            nan_cnt     <= '0;
        end
    end

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_fp_nan_chk.sv
// Self-checking bench for xpu_vpu_pc_tn_vlsu_fp_nan_chk (DW=128).
module tb_xpu_vpu_pc_tn_vlsu_fp_nan_chk;

    localparam int unsigned DW    = 128;
    localparam int unsigned NE    = 8;
    localparam int unsigned CNT_W = 16;

    logic             cpuclk = 1'b0;
    logic             cpurst;
    logic             in_vld;
    logic             in_rdy;
    logic [DW-1:0]    in_data;
    logic [1:0]       in_sew;
    logic [NE-1:0]    in_emask;
    logic             in_canon;
    logic             out_vld;
    logic             out_rdy;
    logic [DW-1:0]    out_data;
    logic [NE-1:0]    out_qnan;
    logic [NE-1:0]    out_snan;
    logic             clr_sticky;
    logic             snan_sticky;
    logic [CNT_W-1:0] nan_cnt;

    always #5 cpuclk = ~cpuclk;

    xpu_vpu_pc_tn_vlsu_fp_nan_chk #(
        .DW(DW), .NE(NE), .CNT_W(CNT_W)
    ) dut (
        .cpuclk(cpuclk), .cpurst(cpurst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_sew(in_sew),
        .in_emask(in_emask), .in_canon(in_canon),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_qnan(out_qnan), .out_snan(out_snan),
        .clr_sticky(clr_sticky), .snan_sticky(snan_sticky), .nan_cnt(nan_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [NE-1:0] q;
        logic [NE-1:0] s;
    } beat_t;

    typedef struct {
        logic [1:0]    sew;
        logic [DW-1:0] data;
        logic [NE-1:0] mask;
        logic          canon;
        logic [DW-1:0] exp_data;
        logic [NE-1:0] exp_q;
        logic [NE-1:0] exp_s;
    } vec_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned mdl_cnt;
    logic        mdl_sticky;
    logic        hold_v;
    beat_t       held;
    logic        last_in_fire, last_out_fire;
    beat_t       cap;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Reference: classification from field arithmetic; canonical value = exp all ones + mantissa MSB
    function automatic beat_t ref_model(input logic [DW-1:0] d, input logic [1:0] sew,
                                        input logic [NE-1:0] m, input logic c);
        beat_t b;
        int unsigned w, ew, mw;
        longint unsigned e, lm, ex, mn, cv;
        logic [DW-1:0] sh;
        b.data = d; b.q = '0; b.s = '0;
        case (sew)
            2'd1: begin w = 16; ew = 5;  end
            2'd2: begin w = 32; ew = 8;  end
            2'd3: begin w = 64; ew = 11; end
            default: return b;
        endcase
        mw = w - 1 - ew;
        lm = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
        cv = ((64'd1 << (ew + 1)) - 1) << (mw - 1);
        for (int unsigned i = 0; i < DW / w; i++) begin
            if (m[i]) begin
                sh = d >> (i * w);
                e  = sh[63:0] & lm;
                ex = (e >> mw) & ((64'd1 << ew) - 1);
                mn = e & ((64'd1 << mw) - 1);
                if (ex == ((64'd1 << ew) - 1) && mn != 0) begin
                    if (((mn >> (mw - 1)) & 1) == 1) b.q[i] = 1'b1;
                    else                             b.s[i] = 1'b1;
                    if (c)
                        b.data = (b.data & ~(DW'(lm) << (i * w))) | (DW'(cv) << (i * w));
                end
            end
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] gen_data(input logic [1:0] sew);
        logic [DW-1:0] d = '0;
        int unsigned w, ew, mw;
        longint unsigned v, lm, r;
        if (sew == 2'd0) begin
            for (int unsigned i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
            return d;
        end
        w  = (sew == 2'd1) ? 16 : (sew == 2'd2) ? 32 : 64;
        ew = (sew == 2'd1) ? 5  : (sew == 2'd2) ? 8  : 11;
        mw = w - 1 - ew;
        lm = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
        for (int unsigned i = 0; i < DW / w; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                2: v = (((64'd1 << ew) - 1) << mw) | (r & ((64'd1 << mw) - 1)) | (64'd1 << (mw - 1));
                3: begin
                    v = r & ((64'd1 << (mw - 1)) - 1);
                    if (v == 0) v = 1;
                    v = v | (((64'd1 << ew) - 1) << mw);
                end
                4: v = ((64'd1 << ew) - 1) << mw;
                default: v = r;
            endcase
            if ($urandom_range(0, 1) == 1) v = v | (64'd1 << (w - 1));
            d = d | (DW'(v & lm) << (i * w));
        end
        return d;
    endfunction

    // One clock: observe transfers at negedge, update model, check sticky/count after the edge
    task automatic tick();
        beat_t b;
        int unsigned pc;
        @(negedge cpuclk);
        last_in_fire  = 1'b0;
        last_out_fire = 1'b0;
        if (cpurst) begin
            exp_q.delete();
            mdl_sticky = 1'b0;
            mdl_cnt    = 0;
            hold_v     = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_vld",  DW'(out_vld),  DW'(1'b1));
                chk("hold_data", out_data,      held.data);
                chk("hold_qnan", DW'(out_qnan), DW'(held.q));
                chk("hold_snan", DW'(out_snan), DW'(held.s));
            end
            if (clr_sticky) begin
                mdl_sticky = 1'b0;
                mdl_cnt    = 0;
            end
            if (out_vld && out_rdy) begin
                last_out_fire = 1'b1;
                cap.data = out_data; cap.q = out_qnan; cap.s = out_snan;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", DW'(out_vld), DW'(1'b0));
                end else begin
                    b = exp_q.pop_front();
                    chk("sb_data", out_data,      b.data);
                    chk("sb_qnan", DW'(out_qnan), DW'(b.q));
                    chk("sb_snan", DW'(out_snan), DW'(b.s));
                    pc = $countones(b.q | b.s);
                    mdl_cnt = (mdl_cnt + pc > 65535) ? 65535 : mdl_cnt + pc;
                    if (b.s != 0) mdl_sticky = 1'b1;
                end
            end
            if (in_vld && in_rdy) begin
                last_in_fire = 1'b1;
                exp_q.push_back(ref_model(in_data, in_sew, in_emask, in_canon));
            end
            hold_v    = out_vld && !out_rdy;
            held.data = out_data; held.q = out_qnan; held.s = out_snan;
        end
        @(posedge cpuclk);
        #1;
        chk("snan_sticky", DW'(snan_sticky), DW'(mdl_sticky));
        chk("nan_cnt",     DW'(nan_cnt),     DW'(mdl_cnt));
    endtask

    task automatic drain();
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        tick();
        chk("drain_empty", DW'(exp_q.size()), DW'(0));
    endtask

    function automatic vec_t mk(input logic [1:0] sew, input logic [DW-1:0] d, input logic [NE-1:0] m,
                                input logic c, input logic [DW-1:0] ed, input logic [NE-1:0] eq,
                                input logic [NE-1:0] es);
        vec_t v;
        v.sew = sew; v.data = d; v.mask = m; v.canon = c;
        v.exp_data = ed; v.exp_q = eq; v.exp_s = es;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin
        int n_acc;
        int lat;
        logic got;

        tbl[0] = mk(2'd2, {32'hFF800000, 32'h3F800000, 32'h7F800001, 32'h7FC00001}, 8'hFF, 1'b0,
                    {32'hFF800000, 32'h3F800000, 32'h7F800001, 32'h7FC00001}, 8'h01, 8'h02);
        tbl[1] = mk(2'd2, {32'hFF800000, 32'h3F800000, 32'h7F800001, 32'h7FC00001}, 8'hFF, 1'b1,
                    {32'hFF800000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000}, 8'h01, 8'h02);
        tbl[2] = mk(2'd1, {8{16'h7C01}}, 8'h0F, 1'b0, {8{16'h7C01}}, 8'h00, 8'h0F);
        tbl[3] = mk(2'd3, {64'h7FF0000000000000, 64'hFFF0000000000001}, 8'hFF, 1'b1,
                    {64'h7FF0000000000000, 64'h7FF8000000000000}, 8'h00, 8'h01);
        tbl[4] = mk(2'd0, {8{16'h7C01}}, 8'hFF, 1'b1, {8{16'h7C01}}, 8'h00, 8'h00);
        tbl[5] = mk(2'd1, {8{16'h7E01}}, 8'hAA, 1'b1, {4{16'h7E00, 16'h7E01}}, 8'hAA, 8'h00);
        tbl[6] = mk(2'd2, {4{32'h7F800001}}, 8'hF0, 1'b1, {4{32'h7F800001}}, 8'h00, 8'h00);

        cpurst = 1'b1; in_vld = 1'b0; in_data = '0; in_sew = 2'd0; in_emask = '0;
        in_canon = 1'b0; out_rdy = 1'b1; clr_sticky = 1'b0;
        hold_v = 1'b0; mdl_cnt = 0; mdl_sticky = 1'b0;
        repeat (3) tick();
        cpurst = 1'b0;
        chk("rst_in_rdy",   DW'(in_rdy),   DW'(1'b1));
        chk("rst_out_vld",  DW'(out_vld),  DW'(1'b0));
        chk("rst_out_data", out_data,      '0);
        chk("rst_qnan",     DW'(out_qnan), '0);
        chk("rst_snan",     DW'(out_snan), '0);
        chk("rst_sticky",   DW'(snan_sticky), '0);
        chk("rst_cnt",      DW'(nan_cnt),  '0);

        // Directed vectors with 2-cycle latency check
        for (int i = 0; i < 7; i++) begin
            in_sew = tbl[i].sew; in_data = tbl[i].data; in_emask = tbl[i].mask;
            in_canon = tbl[i].canon; in_vld = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin tick(); got = last_in_fire; end
            in_vld = 1'b0;
            if (!got) fail_now("vec_accept");
            got = 1'b0; lat = 0;
            for (int k = 0; k < 20 && !got; k++) begin tick(); lat++; got = last_out_fire; end
            if (!got) fail_now("vec_out");
            else begin
                chk("vec_data", cap.data,      tbl[i].exp_data);
                chk("vec_qnan", DW'(cap.q),    DW'(tbl[i].exp_q));
                chk("vec_snan", DW'(cap.s),    DW'(tbl[i].exp_s));
                chk("vec_lat",  DW'(lat),      DW'(2));
            end
            if (i == 0) begin
                chk("vec0_sticky", DW'(snan_sticky), DW'(1'b1));
                chk("vec0_cnt",    DW'(nan_cnt),     DW'(2));
            end
        end
        drain();

        // Backpressure: stall 5 cycles, only two beats fit
        out_rdy = 1'b0; in_vld = 1'b1; in_sew = 2'd1; in_emask = 8'hFF; in_canon = 1'b0;
        in_data = gen_data(2'd1);
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (last_in_fire) begin n_acc++; in_data = gen_data(2'd1); end
        end
        chk("bp_accepted", DW'(n_acc),  DW'(2));
        chk("bp_in_rdy",   DW'(in_rdy), DW'(1'b0));
        drain();

        // clr_sticky together with an sNaN transfer
        in_sew = 2'd1; in_data = {112'h0, 16'h7C01}; in_emask = 8'h01; in_canon = 1'b0;
        in_vld = 1'b1; out_rdy = 1'b0;
        tick();
        in_vld = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin tick(); got = out_vld; end
        if (!got) fail_now("clr_out_vld");
        clr_sticky = 1'b1; out_rdy = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_sticky_set", DW'(snan_sticky), DW'(1'b1));
        chk("clr_cnt_one",    DW'(nan_cnt),     DW'(1));
        drain();

        // Randomised traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            in_vld     = ($urandom_range(0, 3) != 0);
            in_sew     = 2'($urandom_range(0, 3));
            in_data    = gen_data(in_sew);
            in_emask   = 8'($urandom);
            in_canon   = 1'($urandom);
            out_rdy    = ($urandom_range(0, 9) < 7);
            clr_sticky = ($urandom_range(0, 19) == 0);
            tick();
        end
        clr_sticky = 1'b0;
        drain();

        // Saturation: 8192 beats of 8 NaN lanes exceed the 16-bit range
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        in_sew = 2'd1; in_data = {8{16'h7C01}}; in_emask = 8'hFF; in_canon = 1'b0;
        in_vld = 1'b1; out_rdy = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 9000 && n_acc < 8192; k++) begin
            tick();
            if (last_in_fire) n_acc++;
        end
        if (n_acc != 8192) fail_now("sat_stream");
        drain();
        chk("sat_cnt", DW'(nan_cnt), DW'(16'hFFFF));
        in_vld = 1'b1; tick(); in_vld = 1'b0;
        drain();
        chk("sat_cnt_hold", DW'(nan_cnt), DW'(16'hFFFF));

        // Mid-stream reset drops in-flight beats
        in_vld = 1'b1; out_rdy = 1'b0; in_data = {8{16'h7C01}};
        repeat (3) tick();
        cpurst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
        tick();
        cpurst = 1'b0;
        chk("mrst_out_vld", DW'(out_vld),     DW'(1'b0));
        chk("mrst_data",    out_data,         '0);
        chk("mrst_sticky",  DW'(snan_sticky), DW'(1'b0));
        chk("mrst_cnt",     DW'(nan_cnt),     DW'(0));
        chk("mrst_in_rdy",  DW'(in_rdy),      DW'(1'b1));
        repeat (4) tick();
        chk("mrst_quiet", DW'(out_vld), DW'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xpu_vpu_pc_tn_vlsu_fp_nan_chk.md
Name: xpu_vpu_pc_tn_vlsu_fp_nan_chk

Overview:
Multi-element, SEW-configurable IEEE-754 NaN classifier and canonicaliser for the VLSU load/store data path. Each beat of DW bits is split into FP16/FP32/FP64 elements. Every active element is classified as quiet NaN (qNaN) or signalling NaN (sNaN). NaN elements are optionally replaced with the canonical qNaN, and an accumulated sNaN sticky flag plus a NaN element counter are kept. The block sits between the VLSU data-merge stage and the VRF write port, behind a 2-stage valid/ready pipeline.

Parameters:
DW, 128, beat data width in bits; multiple of 64, minimum 64.
NE, DW/16, element-flag width (maximum element count, FP16).
CNT_W, 16, width of the saturating NaN element counter.

Ports:
cpuclk  in  1  clock; all state updates on the rising edge.
cpurst  in  1  synchronous, active-high reset.
in_vld  in  1  input beat valid.
in_rdy  out  1  block can accept an input beat.
in_data  in  DW  packed element data; element i sits at bits [i*SEW +: SEW].
in_sew  in  2  element size: 00 bypass, 01 FP16, 10 FP32, 11 FP64.
in_emask  in  NE  active-element mask; bit i applies to element i; bits at or above DW/SEW are ignored.
in_canon  in  1  replace active NaN elements with the canonical qNaN.
out_vld  out  1  output beat valid.
out_rdy  in  1  downstream accepts the output beat.
out_data  out  DW  result data.
out_qnan  out  NE  per-element qNaN flags.
out_snan  out  NE  per-element sNaN flags.
clr_sticky  in  1  single-cycle clear of snan_sticky and nan_cnt.
snan_sticky  out  1  at least one sNaN has been delivered since the last reset or clear.
nan_cnt  out  CNT_W  saturating count of delivered NaN elements.

Behaviour:
- Classification per element (EXP/MAN widths 5/10, 8/23, 11/52):
  - NaN = exponent all ones AND mantissa nonzero.
  - qNaN = NaN AND mantissa MSB = 1.
  - sNaN = NaN AND mantissa MSB = 0.
  - Sign is ignored.
- An inactive element (emask bit 0) passes through unchanged with both flags 0.
- SEW 00 (bypass): data passes through unchanged, all flags 0, counters untouched.
- Flag bits at or above DW/SEW are 0.
- Canonical qNaN values: FP16 16'h7E00; FP32 32'h7FC00000; FP64 64'h7FF8000000000000.
- When in_canon=1, each active NaN element (quiet or signalling) is replaced with the canonical value of its width. Flags still report the original class.
- Pipeline:
  - S0 registers the raw data, SEW, mask, canon and the classify result.
  - S1 registers the canonicalised data and the flags.
  - Latency is 2 cycles from input acceptance to out_vld under no backpressure.
  - Throughput is 1 beat per cycle.
- Handshake:
  - s1_adv = !s1_vld | out_rdy.
  - in_rdy = !s0_vld | s1_adv (combinational; no combinational path from in_vld to in_rdy).
  - A beat transfers when vld & rdy on the same edge.
  - out_data and the flags stay stable while out_vld=1 and out_rdy=0.
  - out_vld must not drop without a transfer.
- Sticky and counter, updated only on an output transfer (out_vld & out_rdy):
  - snan_sticky is set if any out_snan bit is 1.
  - nan_cnt += popcount(out_qnan | out_snan), saturating at all ones.
- clr_sticky:
  - Clears snan_sticky and nan_cnt.
  - If a transfer happens in the same cycle, the clear applies first and then that beat's contribution is added (set wins for the sticky flag).
- Reset: s0_vld=0, s1_vld=0, out_vld=0, snan_sticky=0, nan_cnt=0, out_data=0, out_qnan=0, out_snan=0.
- in_rdy=1 in the first cycle after reset deasserts.
- Reset mid-stream drops all in-flight beats without any output transfer.

Decomposition:
- Shared package xpu_vpu_pc_tn_vlsu_fp_pkg holds:
  - the SEW encodings;
  - EXP/MAN widths per format;
  - the canonical qNaN constants.
- Sub-module xpu_vpu_pc_tn_vlsu_fp_elem_cls, parametrised by EXPONENT_SIZE and MANTISSA_SIZE.
  - Purely combinational; outputs is_qnan and is_snan.
  - Instantiated for each lane of each format via generate.
- A per-lane SEW mux selects the result.

Test Plan:
- Reset, then FP32 in_data lanes {7FC00001, 7F800001, 3F800000, FF800000}, emask all 1, canon=0 -> output after 2 cycles: out_qnan=0001, out_snan=0010, data unchanged, snan_sticky=1, nan_cnt=2.
- Same beat with canon=1 -> lanes 0 and 1 become 7FC00000, lanes 2 and 3 unchanged, flags identical.
- FP16 beat, all 8 lanes 7C01, emask=8'h0F -> out_snan=0x000F, lanes 4 to 7 unchanged, nan_cnt +=4.
- FP64 lanes {FFF0000000000001, 7FF0000000000000}, canon=1 -> lane 0 becomes 7FF8000000000000 with snan flag bit0=1; lane 1 (infinity) is not flagged.
- Backpressure: out_rdy=0 for 5 cycles while in_vld=1 -> in_rdy drops after 2 beats are accepted, out_data is held stable, and there is no loss or duplication once out_rdy=1.
- clr_sticky with a simultaneous sNaN beat transfer gives snan_sticky=1 and nan_cnt=1. Preloading nan_cnt to all ones and adding a beat leaves it saturated. A mid-stream cpurst clears all state and out_vld=0.
